// File: rtl/pair_match_ctrl.sv
// pair_match_ctrl: game sequencer for the 6x6 pair-matching card array.
// Moves a one-hot cursor, issues select / match-success / match-fail strobes,
// keeps two picked cards on display for HOLD_CYCLES, then resolves the pair
// and tracks how many pairs remain.
// Optional build macro: PAIR_MATCH_MISS_CNT_EN adds an 8-bit saturating
// mismatch counter on output miss_cnt.
//
// state   | meaning
// IDLE    | no card picked, cursor moves and sel accepted
// ONE     | first card picked, cursor moves and sel accepted
// HOLD    | both cards shown, hold timer running
// RESOLVE | one cycle: both cards on cur_bus, ms or mf strobed
// WON     | all pairs found, everything ignored until rst
module pair_match_ctrl #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_sel,
  input  logic [179:0]   face_bus,
  input  logic [35:0]    hidden_bus,
  output logic [35:0]    cur_bus,
  output logic           s,
  output logic           ms,
  output logic           mf,
  output logic [4:0]     pairs_left,
  output logic           busy,
`ifdef PAIR_MATCH_MISS_CNT_EN
  output logic [7:0]     miss_cnt,
`endif
  output logic           won
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ONE     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_WON     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [4:0]       PAIRS_ALL = 5'd18;

  state_t           state;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [5:0]       first_idx;
  logic [5:0]       second_idx;
  logic             match;
  logic [CNT_W-1:0] timer;

  logic [5:0]       cur_idx;
  logic [4:0]       face_cur;
  logic [4:0]       face_first;
  logic             hidden_cur;
  logic             any_move;
  logic [2:0]       mv_row;
  logic [2:0]       mv_col;
  logic [5:0]       mv_idx;

  function automatic logic [35:0] onehot(input logic [5:0] i);
    return 36'(1) << i;
  endfunction

  function automatic logic [2:0] wrap_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd5 : v - 3'd1;
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd5) ? 3'd0 : v + 3'd1;
  endfunction

  // Linear card index under the cursor and the card attributes sampled on sel.
  always_comb begin
    cur_idx    = 6'(int'(row) * 6 + int'(col));
    face_cur   = face_bus[int'(cur_idx) * 5 +: 5];
    face_first = face_bus[int'(first_idx) * 5 +: 5];
    hidden_cur = hidden_bus[cur_idx];
  end

  // Cursor target for this cycle's winning move button (up > down > left > right).
  always_comb begin
    mv_row   = row;
    mv_col   = col;
    any_move = btn_up | btn_down | btn_left | btn_right;
    if (btn_up) begin
      mv_row = wrap_dec(row);
    end else if (btn_down) begin
      mv_row = wrap_inc(row);
    end else if (btn_left) begin
      mv_col = wrap_dec(col);
    end else if (btn_right) begin
      mv_col = wrap_inc(col);
    end
    mv_idx = 6'(int'(mv_row) * 6 + int'(mv_col));
  end

  // Game sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row        <= 3'd0;
      col        <= 3'd0;
      first_idx  <= 6'd0;
      second_idx <= 6'd0;
      match      <= 1'b0;
      timer      <= '0;
      cur_bus    <= 36'h1;
      s          <= 1'b0;
      ms         <= 1'b0;
      mf         <= 1'b0;
      pairs_left <= PAIRS_ALL;
      busy       <= 1'b0;
      won        <= 1'b0;
`ifdef PAIR_MATCH_MISS_CNT_EN
      miss_cnt   <= 8'd0;
`endif
    end else begin
      s  <= 1'b0;
      ms <= 1'b0;
      mf <= 1'b0;
      case (state)
        ST_IDLE, ST_ONE: begin
          // sel wins the cycle even when it lands on a hidden card
          if (btn_sel) begin
            if (!hidden_cur) begin
              s <= 1'b1;
              if (state == ST_IDLE) begin
                first_idx <= cur_idx;
                state     <= ST_ONE;
              end else if (cur_idx == first_idx) begin
                state <= ST_IDLE;
              end else begin
                second_idx <= cur_idx;
                match      <= (face_first == face_cur);
                timer      <= '0;
                busy       <= 1'b1;
                state      <= ST_HOLD;
              end
            end
          end else if (any_move) begin
            row     <= mv_row;
            col     <= mv_col;
            cur_bus <= onehot(mv_idx);
          end
        end

        ST_HOLD: begin
          if (timer == HOLD_LAST) begin
            state   <= ST_RESOLVE;
            cur_bus <= onehot(first_idx) | onehot(second_idx);
            ms      <= match;
            mf      <= ~match;
            if (match && (pairs_left != 5'd0)) begin
              pairs_left <= pairs_left - 5'd1;
            end
`ifdef PAIR_MATCH_MISS_CNT_EN
            if (!match && (miss_cnt != 8'hFF)) begin
              miss_cnt <= miss_cnt + 8'd1;
            end
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_RESOLVE: begin
          // pairs_left already holds the post-decrement value here
          cur_bus <= onehot(cur_idx);
          if (pairs_left == 5'd0) begin
            state <= ST_WON;
            won   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_WON: begin
          state <= ST_WON;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_match_ctrl.sv
// tb_pair_match_ctrl: table vectors, directed game sequences and random
// stimulus for pair_match_ctrl with HOLD_CYCLES=4, checked every cycle
// against a queue-based behavioural model of the game rules.
module tb_pair_match_ctrl;

  localparam int HOLD = 4;
  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_SEL  = 5'b10000;
  localparam logic [4:0] B_UP   = 5'b01000;
  localparam logic [4:0] B_DN   = 5'b00100;
  localparam logic [4:0] B_LT   = 5'b00010;
  localparam logic [4:0] B_RT   = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [179:0] face_bus;
  logic [35:0]  hidden_bus;
  logic [35:0]  cur_bus;
  logic         s, ms, mf, busy, won;
  logic [4:0]   pairs_left;
`ifdef PAIR_MATCH_MISS_CNT_EN
  logic [7:0]   miss_cnt;
`endif

  pair_match_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(26)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel),
    .face_bus(face_bus), .hidden_bus(hidden_bus),
    .cur_bus(cur_bus), .s(s), .ms(ms), .mf(mf),
    .pairs_left(pairs_left), .busy(busy),
`ifdef PAIR_MATCH_MISS_CNT_EN
    .miss_cnt(miss_cnt),
`endif
    .won(won)
  );

  int errors = 0;
  int checks = 0;

  // behavioural model: cursor index, list of picked cards, hold countdown
  int        m_idx;
  int        m_sel[$];
  int        m_hold;
  bit        m_resolving, m_won, m_match;
  int        m_pairs, m_miss;
  logic [35:0] e_cur;
  bit        e_s, e_ms, e_mf;

  typedef struct {
    bit          r;
    logic [4:0]  b;
    logic [35:0] cur;
    bit          s;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [35:0] oh(input int i);
    logic [35:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_sel.delete(); m_hold = 0;
    m_resolving = 0; m_won = 0; m_match = 0;
    m_pairs = 18; m_miss = 0;
    e_cur = oh(0); e_s = 0; e_ms = 0; e_mf = 0;
  endtask

  task automatic model_step(input bit r, input logic [4:0] b);
    int rw, cl;
    e_s = 0; e_ms = 0; e_mf = 0;
    if (r) begin
      model_reset();
    end else if (!m_won) begin
      if (m_resolving) begin
        m_resolving = 0;
        m_sel.delete();
        if (m_pairs == 0) m_won = 1;
        e_cur = oh(m_idx);
      end else if (m_sel.size() == 2) begin
        m_hold--;
        if (m_hold == 0) begin
          m_resolving = 1;
          e_cur = oh(m_sel[0]) | oh(m_sel[1]);
          e_ms = m_match;
          e_mf = !m_match;
          if (m_match) m_pairs--;
          else if (m_miss < 255) m_miss++;
        end
      end else begin
        rw = m_idx / 6;
        cl = m_idx % 6;
        if (b[4]) begin
          if (!hidden_bus[m_idx]) begin
            e_s = 1;
            if (m_sel.size() == 1 && m_sel[0] == m_idx) begin
              m_sel.delete();
            end else begin
              m_sel.push_back(m_idx);
              if (m_sel.size() == 2) begin
                m_hold = HOLD;
                m_match = (face_bus[5*m_sel[0] +: 5] == face_bus[5*m_idx +: 5]);
              end
            end
          end
        end else if (b[3]) rw = (rw + 5) % 6;
        else if (b[2]) rw = (rw + 1) % 6;
        else if (b[1]) cl = (cl + 5) % 6;
        else if (b[0]) cl = (cl + 1) % 6;
        m_idx = rw * 6 + cl;
        e_cur = oh(m_idx);
      end
    end
  endtask

  task automatic cmp_model();
    chk("cur_bus", 64'(cur_bus), 64'(e_cur));
    chk("s", 64'(s), 64'(e_s));
    chk("ms", 64'(ms), 64'(e_ms));
    chk("mf", 64'(mf), 64'(e_mf));
    chk("pairs_left", 64'(pairs_left), 64'(m_pairs));
    chk("busy", 64'(busy), 64'(m_sel.size() == 2 || m_resolving || m_won));
    chk("won", 64'(won), 64'(m_won));
`ifdef PAIR_MATCH_MISS_CNT_EN
    chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
`endif
  endtask

  task automatic step(input bit r, input logic [4:0] b);
    rst = r;
    {btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge clk);
    model_step(r, b);
    #1;
    cmp_model();
  endtask

  task automatic goto_card(input int target);
    for (int i = 0; i < 6 && (m_idx % 6) != (target % 6); i++) step(0, B_RT);
    for (int i = 0; i < 6 && (m_idx / 6) != (target / 6); i++) step(0, B_DN);
    chk("goto", 64'(cur_bus), 64'(oh(target)));
  endtask

  initial begin
    int faces[36];
    int j, t;
    rst = 1; {btn_sel, btn_up, btn_down, btn_left, btn_right} = B_NONE;
    face_bus = '0; hidden_bus = '0;
    model_reset();

    tbl[0]  = '{1, B_NONE, 36'h1, 0};
    tbl[1]  = '{0, B_RT, 36'h1 << 1, 0};
    tbl[2]  = '{0, B_RT, 36'h1 << 2, 0};
    tbl[3]  = '{0, B_DN, 36'h1 << 8, 0};
    tbl[4]  = '{1, B_NONE, 36'h1, 0};
    tbl[5]  = '{0, B_DN, 36'h1 << 6, 0};
    tbl[6]  = '{0, B_LT, 36'h1 << 11, 0};
    tbl[7]  = '{0, B_LT, 36'h1 << 10, 0};
    tbl[8]  = '{0, B_LT, 36'h1 << 9, 0};
    tbl[9]  = '{1, B_NONE, 36'h1, 0};
    tbl[10] = '{0, B_UP, 36'h1 << 30, 0};
    tbl[11] = '{0, B_DN | B_LT | B_RT, 36'h1, 0};
    tbl[12] = '{0, B_SEL | B_UP, 36'h1, 1};
    tbl[13] = '{0, B_SEL, 36'h1, 1};
    tbl[14] = '{0, B_LT | B_RT, 36'h1 << 5, 0};
    tbl[15] = '{1, B_NONE, 36'h1, 0};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].b);
      chk($sformatf("tbl%0d_cur", i), 64'(cur_bus), 64'(tbl[i].cur));
      chk($sformatf("tbl%0d_s", i), 64'(s), 64'(tbl[i].s));
    end
    chk("reset_pairs", 64'(pairs_left), 64'd18);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_won", 64'(won), 64'd0);

    // matching pair at cards 0 and 1
    face_bus = '0; face_bus[4:0] = 5'd3; face_bus[9:5] = 5'd3;
    step(1, B_NONE);
    step(0, B_SEL);  chk("A_s1", 64'(s), 64'd1);
    step(0, B_RT);   chk("A_cur1", 64'(cur_bus), 64'(36'h2));
    step(0, B_SEL);  chk("A_s2", 64'(s), 64'd1); chk("A_busy0", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, B_SEL);
      chk("A_hold_busy", 64'(busy), 64'd1); chk("A_hold_ms", 64'(ms), 64'd0);
      chk("A_hold_s", 64'(s), 64'd0);
    end
    step(0, B_NONE);
    chk("A_res_cur", 64'(cur_bus), 64'(36'h3)); chk("A_res_ms", 64'(ms), 64'd1);
    chk("A_res_mf", 64'(mf), 64'd0); chk("A_res_pairs", 64'(pairs_left), 64'd17);
    step(0, B_NONE);
    chk("A_after_cur", 64'(cur_bus), 64'(36'h2)); chk("A_after_ms", 64'(ms), 64'd0);
    chk("A_after_busy", 64'(busy), 64'd0);

    // mismatching pair at cards 0 (face 2) and 7 (face 9)
    face_bus = '0; face_bus[4:0] = 5'd2; face_bus[39:35] = 5'd9;
    step(1, B_NONE);
    step(0, B_SEL); step(0, B_RT); step(0, B_DN);
    step(0, B_SEL); chk("B_s2", 64'(s), 64'd1);
    repeat (3) step(0, B_NONE);
    step(0, B_NONE);
    chk("B_res_mf", 64'(mf), 64'd1); chk("B_res_ms", 64'(ms), 64'd0);
    chk("B_res_cur", 64'(cur_bus), 64'(36'h81)); chk("B_res_pairs", 64'(pairs_left), 64'd18);
`ifdef PAIR_MATCH_MISS_CNT_EN
    chk("B_miss", 64'(miss_cnt), 64'd1);
`endif
    step(0, B_NONE); chk("B_after_cur", 64'(cur_bus), 64'(36'h80));

    // select/deselect idx 4, then hidden card ignored
    step(1, B_NONE);
    repeat (4) step(0, B_RT);
    step(0, B_SEL); chk("C_s1", 64'(s), 64'd1);
    step(0, B_SEL); chk("C_s2", 64'(s), 64'd1);
    step(0, B_NONE); chk("C_ms", 64'(ms), 64'd0); chk("C_mf", 64'(mf), 64'd0);
    chk("C_busy", 64'(busy), 64'd0);
    step(0, B_SEL); chk("C_s3", 64'(s), 64'd1);
    hidden_bus = 36'h1 << 5;
    step(0, B_RT);
    step(0, B_SEL); chk("C_hidden_s", 64'(s), 64'd0); chk("C_hidden_busy", 64'(busy), 64'd0);
    hidden_bus = '0;

    // reset during HOLD with timer=2
    step(1, B_NONE);
    step(0, B_SEL); step(0, B_RT); step(0, B_SEL);
    step(0, B_NONE); step(0, B_NONE);
    step(1, B_NONE);
    chk("E_cur", 64'(cur_bus), 64'h1); chk("E_busy", 64'(busy), 64'd0);
    chk("E_pairs", 64'(pairs_left), 64'd18); chk("E_s", 64'(s), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, B_NONE);
      chk("E_no_ms", 64'(ms), 64'd0); chk("E_no_mf", 64'(mf), 64'd0);
    end

    // full game: card i has face i/2
    for (int i = 0; i < 36; i++) face_bus[5*i +: 5] = 5'(i / 2);
    hidden_bus = '0;
    step(1, B_NONE);
    for (int k = 0; k < 18; k++) begin
      goto_card(2 * k);
      step(0, B_SEL); step(0, B_RT); step(0, B_SEL);
      repeat (4) step(0, B_NONE);
      chk("D_ms", 64'(ms), 64'd1);
      step(0, B_NONE);
      hidden_bus[2*k] = 1'b1; hidden_bus[2*k+1] = 1'b1;
    end
    chk("D_pairs", 64'(pairs_left), 64'd0); chk("D_won", 64'(won), 64'd1);
    chk("D_busy", 64'(busy), 64'd1);
    hidden_bus = '0;
    step(0, B_SEL); chk("D_won_s", 64'(s), 64'd0); chk("D_won_cur", 64'(cur_bus), 64'(36'h1 << 35));
    step(0, B_UP);  chk("D_won_up", 64'(cur_bus), 64'(36'h1 << 35));
    step(0, B_LT);  chk("D_won_lt", 64'(cur_bus), 64'(36'h1 << 35));

    // random play against the model
    for (int i = 0; i < 36; i++) faces[i] = i / 2;
    for (int i = 35; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = faces[i]; faces[i] = faces[j]; faces[j] = t;
    end
    for (int i = 0; i < 36; i++) face_bus[5*i +: 5] = 5'(faces[i]);
    step(1, B_NONE);
    for (int c = 0; c < 4000; c++) begin
      logic [4:0] b;
      if ((c % 60) == 0) begin
        hidden_bus = '0;
        for (int i = 0; i < 36; i++) if ($urandom_range(7, 0) == 0) hidden_bus[i] = 1'b1;
      end
      b = 5'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) b[4] = 1'b1;
      if ($urandom_range(2, 0) == 0) b = B_NONE;
      step($urandom_range(399, 0) == 0, b);
    end

    rst = 0; {btn_sel, btn_up, btn_down, btn_left, btn_right} = B_NONE;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pair_match_ctrl.md
Name: pair_match_ctrl

Overview:
- Game-sequencing controller for the 36-card (6x6) card array.
- Owns the one-hot cursor and turns debounced button pulses into the array's select / match-success / match-fail strobes.
- Holds two selected cards on display for a fixed time, compares their face IDs, then resolves the pair.
- Tracks remaining pairs and flags the won state.

Parameters:
- HOLD_CYCLES, 50000000, cycles both selected cards stay shown before resolve (1 s at 50 MHz); legal range 1 to 2^CNT_W.
- CNT_W, 26, hold-timer width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_up  in  1  one-cycle pulse, cursor up
- btn_down  in  1  one-cycle pulse, cursor down
- btn_left  in  1  one-cycle pulse, cursor left
- btn_right  in  1  one-cycle pulse, cursor right
- btn_sel  in  1  one-cycle pulse, select card under cursor
- face_bus  in  180  face ID of card i at bits [5i+4:5i]
- hidden_bus  in  36  hidden flags from card array
- cur_bus  out  36  one-hot cursor to card array (two-hot during RESOLVE)
- s  out  1  select-toggle strobe
- ms  out  1  match-success strobe
- mf  out  1  match-fail strobe
- pairs_left  out  5  remaining pairs
- busy  out  1  high in HOLD, RESOLVE, WON
- won  out  1  game complete

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, cursor index 0 (cur_bus = 36'h1), s/ms/mf = 0, pairs_left = 18, busy = 0, won = 0, first/second index = 0, hold timer = 0.
- Cursor: index 0..35, row = idx/6, col = idx%6.
  - Up/down change row by ∓1 and wrap within the column (row 0 up goes to row 5).
  - Left/right change col by ∓1 and wrap within the row.
  - Hidden cards may be traversed.
- Button priority in one cycle: sel > up > down > left > right. Only the winner acts; the others are dropped.
- Moves are accepted only in IDLE and ONE. In other states, moves and sel are ignored.
- Strobes s, ms and mf are single-cycle. They assert the cycle after btn_sel or the resolve decision. cur_bus is guaranteed unchanged while s is high.
- FSM:
  - IDLE: sel on a hidden card is ignored. Sel on a visible card: s=1, first <= idx, go to ONE.
  - ONE:
    - sel on a hidden card is ignored.
    - sel with idx == first: s=1 (deselect), go to IDLE.
    - sel on any other visible card: s=1, second <= idx, match <= (face[first] == face[second]), timer <= 0, go to HOLD.
  - HOLD: timer increments every cycle. When timer == HOLD_CYCLES-1, go to RESOLVE. Total HOLD dwell is exactly HOLD_CYCLES cycles.
  - RESOLVE (one cycle):
    - cur_bus = onehot(first) | onehot(second).
    - ms = match, mf = !match.
    - If match, pairs_left decrements.
    - Next state is WON if the decremented pairs_left == 0, else IDLE.
    - The cycle after RESOLVE, cur_bus returns to onehot(cursor); the cursor value itself is unchanged.
  - WON: won=1, busy=1. All buttons are ignored until rst.
- pairs_left never underflows; decrement happens only in RESOLVE with match.
- Reset mid-operation, any state: abort immediately to reset values. No ms/mf is emitted. The card array is reset by the same rst.
- face_bus and hidden_bus are sampled only on sel cycles; they are assumed stable then.

Optional Feature:
- Macro: PAIR_MATCH_MISS_CNT_EN.
- When defined:
  - Adds output miss_cnt [7:0], reset 0.
  - Increments in each RESOLVE cycle with mf=1 and saturates at 255.
  - Frozen in WON.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan (HOLD_CYCLES=4):
- Reset, then btn_right x2, btn_down x1 -> cur_bus = 1<<8. Then btn_left x3 from idx 6 -> idx 9 (wrap), cur_bus = 1<<9.
- Select idx 0 then idx 1 with equal faces (5'd3) -> s pulses after each sel; busy=1 for 4 HOLD cycles; one RESOLVE cycle with cur_bus = 36'h3, ms=1, mf=0; pairs_left 18 -> 17; then cur_bus = 1<<1.
- Select idx 0 (face 2) and idx 7 (face 9) -> RESOLVE cycle with mf=1, ms=0, cur_bus = (1<<0)|(1<<7); pairs_left stays 18; miss_cnt = 1 if PAIR_MATCH_MISS_CNT_EN is defined.
- Sel idx 4 twice -> two s pulses, state returns to IDLE, no ms/mf. Sel on a card with hidden_bus[i]=1 -> no s. btn_sel and btn_up in the same cycle -> s=1, cursor unchanged.
- Drive 18 matching pairs -> after the last RESOLVE, pairs_left=0, won=1, busy=1; subsequent sel/move produce no s and no cursor change.
- Assert rst during HOLD (timer=2) -> next cycle all outputs are at reset values, and no ms/mf pulse occurs.
